// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizes finished MAC accumulations and streams them out tagged with their pixel address.
// Latency: 2 cycles from mac_valid to out_valid (one capture register, then the result FIFO).
// Backpressure: out_ready stalls the FIFO head; a result arriving at a full FIFO with no pop is dropped and overflow latches.
module ofmap_writeback #(
    parameter int ACC_WIDTH     = 32,
    parameter int OUT_WIDTH     = 8,
    parameter int OW            = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        start,
    input  logic                        mac_valid,
    input  logic signed [ACC_WIDTH-1:0] mac_data,
    input  logic [4:0]                  shift,
    input  logic                        relu_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [ADDR_BITWIDTH-1:0]    out_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_BITWIDTH + OUT_WIDTH;

    localparam logic [ADDR_BITWIDTH-1:0] LAST_PIX = ADDR_BITWIDTH'(OW * OW - 1);
    localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    // Two's complement: -(MAX)-1 is the bitwise inverse of MAX.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Capture stage
    logic                        r_s1_vld;
    logic [OUT_WIDTH-1:0]        r_s1_dat;
    logic [ADDR_BITWIDTH-1:0]    r_s1_addr;
    // Row-major address row*OW+col is simply the number of results captured so far.
    logic [ADDR_BITWIDTH-1:0]    r_pix;

    // Result FIFO
    logic [ENT_W-1:0]            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [CNT_W-1:0]            r_cnt;
    logic [ENT_W-1:0]            r_last;
    logic                        r_overflow;

    logic                        w_cap;
    logic                        w_last;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_drop;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic signed [ACC_WIDTH-1:0] w_relu;
    logic [OUT_WIDTH-1:0]        w_sat;
    logic [ENT_W-1:0]            w_head;

    assign w_cap   = mac_valid && (r_state == S_COLLECT) && !start;
    assign w_last  = (r_pix == LAST_PIX);
    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_pop   = !w_empty && out_ready && !start;
    assign w_push  = r_s1_vld && (!w_full || w_pop) && !start;
    assign w_drop  = r_s1_vld && w_full && !w_pop && !start;

    // Requantize: arithmetic (floor) shift, optional ReLU, saturate to the output range.
    always_comb begin
        w_shifted = mac_data >>> shift;
        w_relu    = (relu_en && w_shifted[ACC_WIDTH-1]) ? '0 : w_shifted;
        if (w_relu > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_relu < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            w_sat = w_relu[OUT_WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start always restarts collection; DRAIN ends on the cycle of the final pop.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_IDLE;
                S_COLLECT: if (w_cap && w_last) w_state_nxt = S_DRAIN;
                S_DRAIN:   if (!r_s1_vld && (w_empty || ((r_cnt == CNT_ONE) && w_pop)))
                               w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Capture register and pixel counter; the counter advances even if the result is later dropped.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1_vld  <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_addr <= '0;
            r_pix     <= '0;
        end else begin
            r_s1_vld <= w_cap;
            if (start) begin
                r_pix <= '0;
            end else if (w_cap) begin
                r_s1_dat  <= w_sat;
                r_s1_addr <= r_pix;
                r_pix     <= r_pix + ADDR_BITWIDTH'(1);
            end
        end
    end

    // FIFO storage; no reset needed since entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s1_addr, r_s1_dat};
        end
    end

    // FIFO pointers, occupancy, last-popped entry and sticky overflow.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else if (start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // When empty, present the last handed-off entry so the outputs do not wander.
    assign w_head    = w_empty ? r_last : r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign out_data  = w_head[OUT_WIDTH-1:0];
    assign out_addr  = w_head[ENT_W-1:OUT_WIDTH];
    assign busy      = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ofmap_writeback.sv
// Testbench for ofmap_writeback: table-driven tiles plus hand-written corner sequences.
// Expected pixels are queued on drive and compared as the DUT hands them off.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ofmap_writeback;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        mac_valid;
    logic [31:0] mac_data;
    logic [4:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_addr;
    logic        busy;
    logic        done;
    logic        overflow;

    ofmap_writeback #(
        .ACC_WIDTH(32), .OUT_WIDTH(8), .OW(3), .FIFO_DEPTH(4), .ADDR_BITWIDTH(4)
    ) dut (
        .clk(clk), .rstN(rstN), .start(start), .mac_valid(mac_valid),
        .mac_data(mac_data), .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  sh;
        logic        relu;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] dat;
        logic [3:0] addr;
    } exp_t;

    vec_t tbl [18];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat   = '0;
    logic [3:0] prev_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [4:0] s, input logic r);
        mac_valid = 1'b1;
        mac_data  = d;
        shift     = s;
        relu_en   = r;
    endtask

    task automatic push_exp(input logic [7:0] d, input int a);
        exp_t e;
        e.dat  = d;
        e.addr = 4'(a);
        sb.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        for (int k = 0; k < max_cyc && !done; k++) tick();
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_sb_empty(input string name, input int max_cyc);
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) tick();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: scoreboard compare on each handshake, hold check while stalled.
    always @(negedge clk) begin
        if (!rstN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_data", 32'(out_data), 32'(prev_dat));
                check("hold_addr", 32'(out_addr), 32'(prev_addr));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data %0h addr %0d, expected no output", out_data, out_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.dat));
                    check("out_addr", 32'(out_addr), 32'(e.addr));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_addr  = out_addr;
        end
    end

    initial begin
        // Tile 1: shift=2 scaling with positive saturation.
        tbl[0]  = '{32'd100, 5'd2, 1'b0, 8'd25};
        tbl[1]  = '{32'd200, 5'd2, 1'b0, 8'd50};
        tbl[2]  = '{32'd300, 5'd2, 1'b0, 8'd75};
        tbl[3]  = '{32'd400, 5'd2, 1'b0, 8'd100};
        tbl[4]  = '{32'd500, 5'd2, 1'b0, 8'd125};
        tbl[5]  = '{32'd600, 5'd2, 1'b0, 8'd127};
        tbl[6]  = '{32'd700, 5'd2, 1'b0, 8'd127};
        tbl[7]  = '{32'd800, 5'd2, 1'b0, 8'd127};
        tbl[8]  = '{32'd900, 5'd2, 1'b0, 8'd127};
        // Tile 2: sign handling, ReLU, floor rounding, extremes.
        tbl[9]  = '{32'hFFFF_FED4, 5'd0,  1'b0, 8'h80};  // -300
        tbl[10] = '{32'hFFFF_FED4, 5'd0,  1'b1, 8'h00};  // -300 relu
        tbl[11] = '{32'hFFFF_FFF9, 5'd1,  1'b0, 8'hFC};  // -7 >>> 1 = -4
        tbl[12] = '{32'hFFFF_FFF9, 5'd1,  1'b1, 8'h00};
        tbl[13] = '{32'd255,       5'd0,  1'b0, 8'h7F};
        tbl[14] = '{32'hFFFF_FF7F, 5'd0,  1'b0, 8'h80};  // -129
        tbl[15] = '{32'hFFFF_FFFF, 5'd4,  1'b0, 8'hFF};  // -1 >>> 4 = -1
        tbl[16] = '{32'h7FFF_FFFF, 5'd31, 1'b0, 8'h00};
        tbl[17] = '{32'h8000_0000, 5'd31, 1'b0, 8'hFF};

        rstN      = 1'b0;
        start     = 1'b0;
        mac_valid = 1'b0;
        mac_data  = '0;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_addr",  32'(out_addr),  32'd0);
        rstN = 1'b1;
        tick();

        // Two table-driven tiles, back-to-back strobes, consumer always ready.
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_start();
            check("start_busy", 32'(busy), 32'd1);
            check("start_done", 32'(done), 32'd0);
            for (int i = 0; i < 9; i++) begin
                drive(tbl[t*9+i].data, tbl[t*9+i].sh, tbl[t*9+i].relu);
                push_exp(tbl[t*9+i].exp, i);
                tick();
            end
            mac_valid = 1'b0;
            check("tile_done_early", 32'(done), 32'd0);
            wait_done("tile_done", 40);
            check("tile_busy_after", 32'(busy), 32'd0);
            check("tile_sb_empty", 32'(sb.size()), 32'd0);
            tick();
            tick();
            check("done_held", 32'(done), 32'd1);
        end

        // mac_valid outside COLLECT is ignored.
        drive(32'd64, 5'd0, 1'b0);
        tick();
        mac_valid = 1'b0;
        tick();
        tick();
        check("ignore_in_done", 32'(out_valid), 32'd0);

        // Backpressure: 5 strobes into a 4-deep FIFO, 5th dropped.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 5; i++) begin
            drive(32'(10 * (i + 1)), 5'd0, 1'b0);
            if (i < 4) push_exp(8'(10 * (i + 1)), i);
            tick();
        end
        mac_valid = 1'b0;
        tick();
        tick();
        check("bp_overflow", 32'(overflow), 32'd1);
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_head",     32'(out_addr),  32'd0);
        out_ready = 1'b1;
        wait_sb_empty("bp_drain", 20);
        for (int i = 5; i < 9; i++) begin
            drive(32'(10 * (i + 1)), 5'd0, 1'b0);
            push_exp(8'(10 * (i + 1)), i);
            tick();
        end
        mac_valid = 1'b0;
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        wait_done("bp_done", 40);

        // Full FIFO with simultaneous push and pop: no drops.
        out_ready = 1'b0;
        do_start();
        check("full_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            out_ready = (i >= 5);
            drive(32'(4 * i + 1), 5'd2, 1'b0);
            push_exp(8'(i), i);
            tick();
        end
        mac_valid = 1'b0;
        wait_done("full_done", 40);
        check("full_no_drop", 32'(overflow), 32'd0);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // Abort mid-tile: start flushes, clears overflow, ignores a coincident strobe.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 5; i++) begin
            drive(32'd33, 5'd0, 1'b0);
            tick();
        end
        mac_valid = 1'b0;
        tick();
        check("abort_pre_ovf", 32'(overflow), 32'd1);
        drive(32'd99, 5'd0, 1'b0);
        do_start();
        mac_valid = 1'b0;
        check("abort_flush_valid", 32'(out_valid), 32'd0);
        check("abort_ovf_clear",   32'(overflow),  32'd0);
        check("abort_busy",        32'(busy),      32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'(i + 2), 5'd1, 1'b1);
            push_exp(8'((i + 2) / 2), i);
            tick();
        end
        mac_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("abort_not_done_8", 32'(done), 32'd0);
        drive(32'd20, 5'd1, 1'b1);
        push_exp(8'd10, 8);
        tick();
        mac_valid = 1'b0;
        wait_done("abort_done", 40);

        // Asynchronous reset in the middle of a drain.
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 9; i++) begin
            drive(32'd5, 5'd0, 1'b0);
            tick();
        end
        mac_valid = 1'b0;
        tick();
        check("pre_rst_busy",  32'(busy),      32'd1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_valid",    32'(out_valid), 32'd0);
        check("arst_busy",     32'(busy),      32'd0);
        check("arst_done",     32'(done),      32'd0);
        check("arst_overflow", 32'(overflow),  32'd0);
        sb.delete();
        tick();
        rstN = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_busy",  32'(busy),      32'd0);
        drive(32'd7, 5'd0, 1'b0);
        tick();
        mac_valid = 1'b0;
        tick();
        tick();
        check("idle_ignore", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
